avl_bus_resp_router: RTL and testbench
======================================

AVL_BUS_RESP_ROUTER -- requirements
Module: avl_bus_resp_router

Interface
REQ-001 Parameter MASTER_NUM, default 8, number of masters behind the n-to-1 arbiter; legal range 1..16.
REQ-002 Parameter DATA_W, default 32, read data width.
REQ-003 Parameter BURST_W, default 8, burst count width.
REQ-004 Parameter FIFO_DEPTH, default 8, number of outstanding read commands tracked; power of two, minimum 2.
REQ-005 SEL_W SHALL equal max(1, $clog2(MASTER_NUM)).
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rest  in  1  reset, synchronous, active-high.
REQ-008 sel  in  SEL_W  grant index from the arbiter for the current command.
REQ-009 cmd_read  in  1  current downstream command is a read.
REQ-010 cmd_accept  in  1  downstream slave accepted the current command (request_ready).
REQ-011 cmd_begin_burst  in  1  current command starts a burst.
REQ-012 cmd_burst_count  in  BURST_W  beats in the burst; valid with cmd_begin_burst.
REQ-013 s_read_data  in  DATA_W  read data from the slave.
REQ-014 s_read_data_valid  in  1  read data beat valid.
REQ-015 m_read_data  out  DATA_W  read data, broadcast to all masters.
REQ-016 m_read_data_valid  out  MASTER_NUM  one-hot valid to the owning master.
REQ-017 cmd_stall  out  1  tracking FIFO full; upstream SHALL NOT issue a read while high.
REQ-018 outstanding  out  $clog2(FIFO_DEPTH)+1  number of queued read entries.
REQ-019 err_overflow  out  1  sticky: read accepted while FIFO full.
REQ-020 err_unexpected  out  1  sticky: data beat received with no queued entry.

Function
REQ-021 Push: when cmd_accept && cmd_read && !(burst continuation), write entry {sel, beats} at the tail; beats = cmd_burst_count if cmd_begin_burst, else 1; a burst_count of 0 SHALL be stored as 1.
REQ-022 Burst continuation: after an accepted cmd_begin_burst read with N beats, the next N-1 accepted read commands SHALL NOT push. An internal command-beat counter tracks these beats.
REQ-023 Head beat counter: loaded from the head entry's beats; decremented on each s_read_data_valid.
REQ-024 Pop: the head entry SHALL pop on the beat that brings the head counter to zero. The counter then reloads from the next entry.
REQ-025 Routing: on s_read_data_valid with FIFO non-empty, at the next edge:
- m_read_data <= s_read_data
- m_read_data_valid <= one-hot(head sel)
Latency is exactly 1 cycle. m_read_data_valid returns to 0 in cycles with no input beat. m_read_data holds its last value.
REQ-026 Simultaneous push and pop SHALL both take effect; outstanding is unchanged.
REQ-027 cmd_stall = (outstanding == FIFO_DEPTH), combinational from registered count.
REQ-028 Push while full: the entry is dropped, pointers are unchanged, and err_overflow is set, even if a pop occurs in the same cycle.
REQ-029 Beat while empty, including the cycle of the first push into an empty FIFO: no valid is asserted, the data is dropped, and err_unexpected is set.
REQ-030 Pointers SHALL wrap modulo FIFO_DEPTH; a FIFO of FIFO_DEPTH entries is fully usable.
REQ-031 A head sel ≥ MASTER_NUM SHALL produce all-zero m_read_data_valid.
REQ-032 Write commands (cmd_read=0) SHALL NOT affect FIFO, counters or errors.

Reset
REQ-033 rest=1 at a clock edge SHALL clear the following: FIFO pointers, outstanding, head and command beat counters, m_read_data_valid, m_read_data, err_overflow, err_unexpected.
REQ-034 Reset mid-burst or with reads outstanding SHALL discard all entries; data beats arriving after reset count as unexpected.
REQ-035 cmd_stall SHALL be 0 in the first cycle after reset.

Verification
REQ-036 Single reads: accept reads with sel=2, then sel=5; return 2 beats A, B -> m_read_data_valid=8'h04 with A one cycle after beat A, then 8'h20 with B; outstanding goes 2→1→0.
REQ-037 Burst: begin_burst read, sel=3, count=4, followed by 3 continuation accepts. Return 4 beats -> 4 consecutive valid=8'h08; outstanding=1 throughout and 0 after the 4th beat.
REQ-038 Full: FIFO_DEPTH=8, 8 reads with no responses -> cmd_stall=1, outstanding=8. A 9th accept sets err_overflow=1 and outstanding stays 8. Draining 8 beats routes in push order.
REQ-039 Same-cycle push and pop with outstanding=3 -> outstanding stays 3. Routing order is preserved across pointer wrap over 20 mixed reads.
REQ-040 Beat with empty FIFO -> m_read_data_valid=0 and err_unexpected=1. Assert rest mid-burst -> all outputs 0, then routing resumes correctly on new reads.

Source files
------------

// File: rtl/avl_bus_resp_router_if.sv
// Bus bundle between the n-to-1 arbiter/slave side and the read-response router.
// The "slave" modport is the router's view; "master" is the driver's view.
interface avl_bus_resp_router_if #(
   parameter int MASTER_NUM = 8,
   parameter int DATA_W     = 32,
   parameter int BURST_W    = 8,
   parameter int FIFO_DEPTH = 8
);
   localparam int SEL_W = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [SEL_W-1:0]      sel;
   logic                  cmd_read;
   logic                  cmd_accept;
   logic                  cmd_begin_burst;
   logic [BURST_W-1:0]    cmd_burst_count;
   logic [DATA_W-1:0]     s_read_data;
   logic                  s_read_data_valid;
   logic [DATA_W-1:0]     m_read_data;
   logic [MASTER_NUM-1:0] m_read_data_valid;
   logic                  cmd_stall;
   logic [CNT_W-1:0]      outstanding;
   logic                  err_overflow;
   logic                  err_unexpected;

   modport slave (
      input  sel, cmd_read, cmd_accept, cmd_begin_burst, cmd_burst_count,
      input  s_read_data, s_read_data_valid,
      output m_read_data, m_read_data_valid, cmd_stall, outstanding,
      output err_overflow, err_unexpected
   );

   modport master (
      output sel, cmd_read, cmd_accept, cmd_begin_burst, cmd_burst_count,
      output s_read_data, s_read_data_valid,
      input  m_read_data, m_read_data_valid, cmd_stall, outstanding,
      input  err_overflow, err_unexpected
   );
endinterface

// File: rtl/avl_bus_resp_router.sv
// Tracks accepted read commands in a FIFO of {grant, beats} entries and routes
// returning read beats to the master that issued them, one cycle later.
module avl_bus_resp_router #(
   parameter int MASTER_NUM = 8,
   parameter int DATA_W     = 32,
   parameter int BURST_W    = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic clk,
   input  logic rest,
   avl_bus_resp_router_if.slave bus
);
   localparam int SEL_W = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [SEL_W-1:0]      r_selMem  [FIFO_DEPTH];
   logic [BURST_W-1:0]    r_beatMem [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wrPtr;
   logic [PTR_W-1:0]      r_rdPtr;
   logic [CNT_W-1:0]      r_count;
   logic [BURST_W-1:0]    r_headCnt;
   logic [BURST_W-1:0]    r_cmdCnt;
   logic [MASTER_NUM-1:0] r_valid;
   logic [DATA_W-1:0]     r_data;
   logic                  r_errOvf;
   logic                  r_errUnx;

   logic                  w_accRead;
   logic                  w_cont;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_pushReq;
   logic                  w_push;
   logic                  w_beat;
   logic                  w_pop;
   logic [BURST_W-1:0]    w_entryBeats;
   logic [BURST_W-1:0]    w_headRem;
   logic [SEL_W-1:0]      w_headSel;
   logic [MASTER_NUM-1:0] w_oneHot;

   assign w_accRead    = bus.cmd_accept && bus.cmd_read;
   assign w_cont       = (r_cmdCnt != '0);
   assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_empty      = (r_count == '0);
   assign w_pushReq    = w_accRead && !w_cont;
   assign w_push       = w_pushReq && !w_full;
   assign w_entryBeats = (bus.cmd_begin_burst && (bus.cmd_burst_count != '0)) ?
                         bus.cmd_burst_count : BURST_W'(1);
   // A head counter of zero means "not yet loaded": take the count straight from the entry.
   assign w_headRem    = (r_headCnt == '0) ? r_beatMem[r_rdPtr] : r_headCnt;
   assign w_headSel    = r_selMem[r_rdPtr];
   assign w_beat       = bus.s_read_data_valid && !w_empty;
   assign w_pop        = w_beat && (w_headRem == BURST_W'(1));

   always_comb begin
      w_oneHot = '0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         if (w_headSel == SEL_W'(i)) w_oneHot[i] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_selMem[r_wrPtr]  <= bus.sel;
         r_beatMem[r_wrPtr] <= w_entryBeats;
      end
   end

   always_ff @(posedge clk) begin
      if (rest) begin
         r_wrPtr   <= '0;
         r_rdPtr   <= '0;
         r_count   <= '0;
         r_headCnt <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
         if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (w_beat) r_headCnt <= w_pop ? '0 : (w_headRem - BURST_W'(1));
      end
   end

   // Remaining continuation beats of the burst command currently being issued.
   always_ff @(posedge clk) begin
      if (rest) begin
         r_cmdCnt <= '0;
      end else if (w_accRead) begin
         if (w_cont)                                                   r_cmdCnt <= r_cmdCnt - BURST_W'(1);
         else if (bus.cmd_begin_burst && (bus.cmd_burst_count != '0))  r_cmdCnt <= bus.cmd_burst_count - BURST_W'(1);
         else                                                          r_cmdCnt <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rest) begin
         r_valid  <= '0;
         r_data   <= '0;
         r_errOvf <= 1'b0;
         r_errUnx <= 1'b0;
      end else begin
         r_valid <= w_beat ? w_oneHot : '0;
         if (w_beat) r_data <= bus.s_read_data;
         if (w_pushReq && w_full) r_errOvf <= 1'b1;
         if (bus.s_read_data_valid && w_empty) r_errUnx <= 1'b1;
      end
   end

   assign bus.m_read_data       = r_data;
   assign bus.m_read_data_valid = r_valid;
   assign bus.cmd_stall         = w_full;
   assign bus.outstanding       = r_count;
   assign bus.err_overflow      = r_errOvf;
   assign bus.err_unexpected    = r_errUnx;
endmodule

// File: tb/tb_avl_bus_resp_router.sv
// Directed bench for avl_bus_resp_router: single reads, bursts, full FIFO,
// simultaneous push/pop with pointer wrap, unexpected beats and mid-burst reset.
module tb_avl_bus_resp_router;
   localparam int MN = 8;
   localparam int DW = 32;
   localparam int BW = 8;
   localparam int FD = 8;

   logic clk = 1'b0;
   logic rest;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   avl_bus_resp_router_if #(.MASTER_NUM(MN), .DATA_W(DW), .BURST_W(BW), .FIFO_DEPTH(FD)) bus ();

   avl_bus_resp_router #(.MASTER_NUM(MN), .DATA_W(DW), .BURST_W(BW), .FIFO_DEPTH(FD)) dut (
      .clk  (clk),
      .rest (rest),
      .bus  (bus.slave)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idleInputs();
      bus.sel               = '0;
      bus.cmd_read          = 1'b0;
      bus.cmd_accept        = 1'b0;
      bus.cmd_begin_burst   = 1'b0;
      bus.cmd_burst_count   = '0;
      bus.s_read_data       = '0;
      bus.s_read_data_valid = 1'b0;
   endtask

   // Drive one cycle of inputs, step past the rising edge, then return to idle.
   task automatic applyStimulus(input logic rd, input logic acc, input logic bb,
                                input logic [7:0] cnt, input logic [2:0] s,
                                input logic bv, input logic [31:0] d);
      bus.cmd_read          = rd;
      bus.cmd_accept        = acc;
      bus.cmd_begin_burst   = bb;
      bus.cmd_burst_count   = cnt;
      bus.sel               = s;
      bus.s_read_data_valid = bv;
      bus.s_read_data       = d;
      @(posedge clk);
      #1;
      idleInputs();
   endtask

   task automatic sendRead(input logic [2:0] s);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, s, 1'b0, 32'h0);
   endtask

   task automatic sendBeat(input logic [31:0] d);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b1, d);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rest = 1'b1;
      idleInputs();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_valid", 32'(bus.m_read_data_valid), 32'h0);
      checkOutput("rst_data", bus.m_read_data, 32'h0);
      checkOutput("rst_outstanding", 32'(bus.outstanding), 32'd0);
      checkOutput("rst_errs", {30'd0, bus.err_overflow, bus.err_unexpected}, 32'h0);
      rest = 1'b0;
      checkOutput("rst_stall", 32'(bus.cmd_stall), 32'd0);

      // Two single reads returned in order
      sendRead(3'd2);
      checkOutput("single_out1", 32'(bus.outstanding), 32'd1);
      sendRead(3'd5);
      checkOutput("single_out2", 32'(bus.outstanding), 32'd2);
      sendBeat(32'hAAAA0001);
      checkOutput("single_validA", 32'(bus.m_read_data_valid), 32'h04);
      checkOutput("single_dataA", bus.m_read_data, 32'hAAAA0001);
      checkOutput("single_outA", 32'(bus.outstanding), 32'd1);
      sendBeat(32'hBBBB0002);
      checkOutput("single_validB", 32'(bus.m_read_data_valid), 32'h20);
      checkOutput("single_dataB", bus.m_read_data, 32'hBBBB0002);
      checkOutput("single_outB", 32'(bus.outstanding), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 32'h0);
      checkOutput("idle_valid", 32'(bus.m_read_data_valid), 32'h0);
      checkOutput("idle_data_hold", bus.m_read_data, 32'hBBBB0002);

      // Burst of 4 with three continuation accepts
      applyStimulus(1'b1, 1'b1, 1'b1, 8'd4, 3'd3, 1'b0, 32'h0);
      checkOutput("burst_out_begin", 32'(bus.outstanding), 32'd1);
      for (int i = 0; i < 3; i++) begin
         sendRead(3'd3);
         checkOutput("burst_out_cont", 32'(bus.outstanding), 32'd1);
      end
      for (int i = 0; i < 4; i++) begin
         sendBeat(32'hC0DE0000 + 32'(i));
         checkOutput("burst_valid", 32'(bus.m_read_data_valid), 32'h08);
         checkOutput("burst_data", bus.m_read_data, 32'hC0DE0000 + 32'(i));
         checkOutput("burst_out", 32'(bus.outstanding), (i == 3) ? 32'd0 : 32'd1);
      end

      // Burst count of zero is a single-beat entry
      applyStimulus(1'b1, 1'b1, 1'b1, 8'd0, 3'd1, 1'b0, 32'h0);
      sendRead(3'd6);
      checkOutput("bc0_out", 32'(bus.outstanding), 32'd2);
      sendBeat(32'h11);
      checkOutput("bc0_valid1", 32'(bus.m_read_data_valid), 32'h02);
      sendBeat(32'h22);
      checkOutput("bc0_valid2", 32'(bus.m_read_data_valid), 32'h40);
      checkOutput("bc0_out_end", 32'(bus.outstanding), 32'd0);

      // Write commands are invisible, including a write burst
      applyStimulus(1'b0, 1'b1, 1'b1, 8'd3, 3'd4, 1'b0, 32'h0);
      checkOutput("write_out", 32'(bus.outstanding), 32'd0);
      sendRead(3'd7);
      checkOutput("write_then_read_out", 32'(bus.outstanding), 32'd1);
      sendBeat(32'h77);
      checkOutput("write_then_read_valid", 32'(bus.m_read_data_valid), 32'h80);

      // Fill, overflow, drain
      for (int i = 0; i < FD; i++) sendRead(3'(i));
      checkOutput("full_out", 32'(bus.outstanding), 32'd8);
      checkOutput("full_stall", 32'(bus.cmd_stall), 32'd1);
      checkOutput("full_ovf_pre", 32'(bus.err_overflow), 32'd0);
      sendRead(3'd1);
      checkOutput("ovf_flag", 32'(bus.err_overflow), 32'd1);
      checkOutput("ovf_out", 32'(bus.outstanding), 32'd8);
      for (int i = 0; i < FD; i++) begin
         sendBeat(32'hD0 + 32'(i));
         checkOutput("drain_valid", 32'(bus.m_read_data_valid), 32'h1 << i);
         checkOutput("drain_out", 32'(bus.outstanding), 32'(7 - i));
      end
      checkOutput("drain_stall", 32'(bus.cmd_stall), 32'd0);
      checkOutput("ovf_sticky", 32'(bus.err_overflow), 32'd1);

      // Simultaneous push and pop at outstanding 3
      sendRead(3'd1);
      sendRead(3'd2);
      sendRead(3'd3);
      checkOutput("pp_out_pre", 32'(bus.outstanding), 32'd3);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 3'd4, 1'b1, 32'hE1);
      checkOutput("pp_valid", 32'(bus.m_read_data_valid), 32'h02);
      checkOutput("pp_out", 32'(bus.outstanding), 32'd3);
      sendBeat(32'hE2);
      checkOutput("pp_drain1", 32'(bus.m_read_data_valid), 32'h04);
      sendBeat(32'hE3);
      checkOutput("pp_drain2", 32'(bus.m_read_data_valid), 32'h08);
      sendBeat(32'hE4);
      checkOutput("pp_drain3", 32'(bus.m_read_data_valid), 32'h10);
      checkOutput("pp_out_end", 32'(bus.outstanding), 32'd0);

      // Twenty reads through the wrapping pointers, one beat each
      sendRead(3'd0);
      for (int i = 1; i < 20; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 3'((i * 3) % 8), 1'b1, 32'(i));
         checkOutput("wrap_valid", 32'(bus.m_read_data_valid), 32'h1 << (((i - 1) * 3) % 8));
         checkOutput("wrap_out", 32'(bus.outstanding), 32'd1);
      end
      sendBeat(32'hF0);
      checkOutput("wrap_last_valid", 32'(bus.m_read_data_valid), 32'h02);
      checkOutput("wrap_out_end", 32'(bus.outstanding), 32'd0);
      checkOutput("unx_pre", 32'(bus.err_unexpected), 32'd0);

      // Beat arriving in the same cycle as the first push into an empty FIFO
      applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 3'd2, 1'b1, 32'h99);
      checkOutput("unx_valid", 32'(bus.m_read_data_valid), 32'h0);
      checkOutput("unx_flag", 32'(bus.err_unexpected), 32'd1);
      checkOutput("unx_out", 32'(bus.outstanding), 32'd1);
      sendBeat(32'h9A);
      checkOutput("unx_then_valid", 32'(bus.m_read_data_valid), 32'h04);

      // Reset in the middle of a burst
      applyStimulus(1'b1, 1'b1, 1'b1, 8'd4, 3'd3, 1'b0, 32'h0);
      sendBeat(32'h1234);
      checkOutput("mid_valid", 32'(bus.m_read_data_valid), 32'h08);
      rest = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 32'h0);
      rest = 1'b0;
      checkOutput("mrst_valid", 32'(bus.m_read_data_valid), 32'h0);
      checkOutput("mrst_data", bus.m_read_data, 32'h0);
      checkOutput("mrst_out", 32'(bus.outstanding), 32'd0);
      checkOutput("mrst_stall", 32'(bus.cmd_stall), 32'd0);
      checkOutput("mrst_errs", {30'd0, bus.err_overflow, bus.err_unexpected}, 32'h0);
      sendBeat(32'h5555);
      checkOutput("mrst_late_valid", 32'(bus.m_read_data_valid), 32'h0);
      checkOutput("mrst_late_unx", 32'(bus.err_unexpected), 32'd1);
      sendRead(3'd5);
      checkOutput("mrst_new_out", 32'(bus.outstanding), 32'd1);
      sendBeat(32'h55);
      checkOutput("mrst_new_valid", 32'(bus.m_read_data_valid), 32'h20);
      checkOutput("mrst_new_data", bus.m_read_data, 32'h55);
      checkOutput("mrst_new_out_end", 32'(bus.outstanding), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
